// File: rtl/time_keeper_bcd_pkg.sv
// Shared clock/alarm definitions: BCD limits, blank digit code and the alarm FSM states.
// Also used by the display controller.
package clock_pkg;
  localparam logic [3:0] BLANK    = 4'hF;
  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;

  typedef enum logic {IDLE = 1'b0, RING = 1'b1} alarm_state_e;

  // Leading-zero suppression for an hour field; values used internally stay unblanked.
  function automatic logic [7:0] blank_lead(input logic [7:0] v, input logic en);
    return (en && v[7:4] == 4'h0) ? {BLANK, v[3:0]} : v;
  endfunction
endpackage

// File: rtl/time_keeper_bcd_if.sv
// Key inputs and BCD time/alarm outputs of the time keeper.
interface time_keeper_bcd_if;
  logic       AdjMinKey;
  logic       AdjHourKey;
  logic       SetAlarm;
  logic       AlarmEn;
  logic [7:0] Hour;
  logic [7:0] Minutes;
  logic [7:0] Second;
  logic [7:0] AHour;
  logic [7:0] AMinutes;
  logic       Alarm;
  logic       TickSec;

  modport master (
    output AdjMinKey, AdjHourKey, SetAlarm, AlarmEn,
    input  Hour, Minutes, Second, AHour, AMinutes, Alarm, TickSec
  );
  modport slave (
    input  AdjMinKey, AdjHourKey, SetAlarm, AlarmEn,
    output Hour, Minutes, Second, AHour, AMinutes, Alarm, TickSec
  );
endinterface

// File: rtl/time_keeper_bcd_counter.sv
// Two-digit packed-BCD counter 00..MAX with a combinational terminal-count carry.
module bcd_mod_counter #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       inc_i,
  output logic [7:0] value_o,
  output logic       carry_o
);
  logic [7:0] value_q, value_d;

  assign carry_o = inc_i && (value_q == MAX);
  assign value_o = value_q;

  always_comb begin
    value_d = value_q;
    if (inc_i) begin
      if (value_q == MAX)           value_d = 8'h00;
      else if (value_q[3:0] == 4'h9) value_d = {value_q[7:4] + 4'h1, 4'h0};
      else                           value_d = {value_q[7:4], value_q[3:0] + 4'h1};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) value_q <= 8'h00;
    else       value_q <= value_d;
  end
endmodule

// File: rtl/time_keeper_bcd.sv
// Time-of-day and alarm keeper: 1 s prescaler, synchronised adjust keys, BCD counters,
// alarm ring FSM and hour leading-zero blanking at the outputs.
module time_keeper_bcd
  import clock_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int RING_SECONDS = 60,
  parameter bit BLANK_LEAD   = 1'b1
) (
  input  logic               CP1,
  input  logic               CR,
  time_keeper_bcd_if.slave   bus
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int RW = (RING_SECONDS > 0) ? $clog2(RING_SECONDS + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST  = PW'(CLK_HZ - 1);
  localparam logic [RW-1:0] RING_LAST = RW'(RING_SECONDS - 1);

  // Prescaler
  logic [PW-1:0] pre_q, pre_d;
  logic          tick, tick_d_q;

  assign tick  = (pre_q == PRE_LAST);
  assign pre_d = tick ? '0 : pre_q + 1'b1;

  always_ff @(posedge CP1 or posedge CR) begin
    if (CR) begin
      pre_q    <= '0;
      tick_d_q <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      tick_d_q <= tick;
    end
  end

  // Key synchronisers, bit 0 = minute key, bit 1 = hour key
  logic [1:0] sync1_q, sync2_q, prev_q, key_pulse;

  assign key_pulse = sync2_q & ~prev_q;

  always_ff @(posedge CP1 or posedge CR) begin
    if (CR) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= {bus.AdjHourKey, bus.AdjMinKey};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Increment muxing: an adjust replaces the tick carry into its field for that cycle
  logic clk_min_adj, clk_hour_adj, al_min_adj, al_hour_adj;
  logic sec_carry, min_carry;
  logic min_inc, hour_inc;
  logic [2:0] unused_carries;
  logic [7:0] sec, min, hour, amin, ahour;

  assign clk_min_adj  = key_pulse[0] & ~bus.SetAlarm;
  assign clk_hour_adj = key_pulse[1] & ~bus.SetAlarm;
  assign al_min_adj   = key_pulse[0] &  bus.SetAlarm;
  assign al_hour_adj  = key_pulse[1] &  bus.SetAlarm;
  assign min_inc      = clk_min_adj | sec_carry;
  assign hour_inc     = clk_hour_adj | (min_carry & ~clk_min_adj);

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk_i(CP1), .rst_i(CR), .inc_i(tick), .value_o(sec), .carry_o(sec_carry));
  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk_i(CP1), .rst_i(CR), .inc_i(min_inc), .value_o(min), .carry_o(min_carry));
  bcd_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk_i(CP1), .rst_i(CR), .inc_i(hour_inc), .value_o(hour), .carry_o(unused_carries[0]));
  bcd_mod_counter #(.MAX(MIN_MAX)) u_amin (
    .clk_i(CP1), .rst_i(CR), .inc_i(al_min_adj), .value_o(amin), .carry_o(unused_carries[1]));
  bcd_mod_counter #(.MAX(HOUR_MAX)) u_ahour (
    .clk_i(CP1), .rst_i(CR), .inc_i(al_hour_adj), .value_o(ahour), .carry_o(unused_carries[2]));

  // Alarm FSM; trigger uses tick_d so it fires once per matching minute
  alarm_state_e  state_q, state_d;
  logic [RW-1:0] ring_cnt_q, ring_cnt_d;
  logic          alarm_hit;

  assign alarm_hit = tick_d_q && bus.AlarmEn && (hour == ahour) && (min == amin) && (sec == 8'h00);

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    case (state_q)
      IDLE: begin
        if (alarm_hit) begin
          state_d    = RING;
          ring_cnt_d = '0;
        end
      end
      RING: begin
        if (!bus.AlarmEn || (|key_pulse)) begin
          state_d = IDLE;
        end else if (tick) begin
          if (ring_cnt_q == RING_LAST) state_d = IDLE;
          else                         ring_cnt_d = ring_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CP1 or posedge CR) begin
    if (CR) begin
      state_q    <= IDLE;
      ring_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
    end
  end

  assign bus.Hour     = blank_lead(hour, BLANK_LEAD);
  assign bus.AHour    = blank_lead(ahour, BLANK_LEAD);
  assign bus.Minutes  = min;
  assign bus.Second   = sec;
  assign bus.AMinutes = amin;
  assign bus.Alarm    = (state_q == RING);
  assign bus.TickSec  = tick_d_q;
endmodule

// File: tb/tb_time_keeper_bcd.sv
// Bench for time_keeper_bcd: integer time-of-day reference model checked every cycle,
// an alarm-adjust vector table, directed corner sequences and a random key phase.
module tb_time_keeper_bcd;
  localparam int CLK_HZ = 4;
  localparam int RING_S = 3;

  logic CP1 = 1'b0;
  logic CR  = 1'b0;
  time_keeper_bcd_if bus();

  time_keeper_bcd #(.CLK_HZ(CLK_HZ), .RING_SECONDS(RING_S), .BLANK_LEAD(1'b1)) dut (
    .CP1(CP1), .CR(CR), .bus(bus));

  always #5 CP1 = ~CP1;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: plain integers for the time, key-level history for edge detection
  typedef struct packed {
    int h; int m; int s; int ah; int am; int pc; int left;
    bit ring; bit tick_d;
    bit [2:0] kmin; bit [2:0] khour;
  } model_t;
  model_t mdl;

  function automatic model_t step(model_t c, bit km, bit kh, bit sa, bit en);
    model_t n = c;
    bit tick = (c.pc == CLK_HZ - 1);
    bit pm = c.kmin[1] & ~c.kmin[2];
    bit ph = c.khour[1] & ~c.khour[2];
    n.pc = tick ? 0 : c.pc + 1;
    n.tick_d = tick;
    n.kmin  = {c.kmin[1:0], km};
    n.khour = {c.khour[1:0], kh};
    if (tick) begin
      n.s = (c.s + 1) % 60;
      if (c.s == 59 && !(pm && !sa)) begin
        n.m = (c.m + 1) % 60;
        if (c.m == 59 && !(ph && !sa)) n.h = (c.h + 1) % 24;
      end
    end
    if (pm && !sa) n.m  = (c.m + 1) % 60;
    if (ph && !sa) n.h  = (c.h + 1) % 24;
    if (pm && sa)  n.am = (c.am + 1) % 60;
    if (ph && sa)  n.ah = (c.ah + 1) % 24;
    if (c.ring) begin
      if (!en || pm || ph) n.ring = 1'b0;
      else if (tick) begin
        n.left = c.left - 1;
        if (n.left == 0) n.ring = 1'b0;
      end
    end else if (c.tick_d && en && c.h == c.ah && c.m == c.am && c.s == 0) begin
      n.ring = 1'b1;
      n.left = RING_S;
    end
    return n;
  endfunction

  always @(posedge CP1 or posedge CR) begin
    if (CR) mdl <= '0;
    else    mdl <= step(mdl, bus.AdjMinKey, bus.AdjHourKey, bus.SetAlarm, bus.AlarmEn);
  end

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [7:0] bhour(input int v);
    return (v < 10) ? {4'hF, 4'(v)} : bcd(v);
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CP1) begin
    if (chk_en && !CR) begin
      chk("m_Hour",     bus.Hour,          bhour(mdl.h));
      chk("m_Minutes",  bus.Minutes,       bcd(mdl.m));
      chk("m_Second",   bus.Second,        bcd(mdl.s));
      chk("m_AHour",    bus.AHour,         bhour(mdl.ah));
      chk("m_AMinutes", bus.AMinutes,      bcd(mdl.am));
      chk("m_Alarm",    8'(bus.Alarm),     8'(mdl.ring));
      chk("m_TickSec",  8'(bus.TickSec),   8'(mdl.tick_d));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CP1);
  endtask

  // One key press, returning once the resulting pulse has been applied
  task automatic press(input bit hour_key);
    if (hour_key) bus.AdjHourKey = 1'b1;
    else          bus.AdjMinKey  = 1'b1;
    cyc(1);
    bus.AdjHourKey = 1'b0;
    bus.AdjMinKey  = 1'b0;
    cyc(3);
  endtask

  task automatic do_reset;
    @(negedge CP1);
    CR = 1'b1;
    bus.AdjMinKey = 1'b0; bus.AdjHourKey = 1'b0;
    bus.SetAlarm = 1'b0;  bus.AlarmEn = 1'b0;
    cyc(2);
    CR = 1'b0;
  endtask

  // Negative fields are don't-care; an expired budget counts as a failure
  task automatic wait_hms(input int h, input int m, input int s, input int budget, input string nm);
    int i;
    for (i = 0; i < budget; i++) begin
      if ((h < 0 || mdl.h == h) && (m < 0 || mdl.m == m) && (s < 0 || mdl.s == s)) break;
      @(negedge CP1);
    end
    n_tests++;
    if (i == budget) begin
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles waiting for %0d:%0d:%0d", nm, budget, h, m, s);
    end
  endtask

  task automatic goto_time(input int h, input int m, input int smax);
    bus.SetAlarm = 1'b0;
    for (int it = 0; it < 6; it++) begin
      for (int g = 0; g < 60 && mdl.m != m; g++) press(1'b0);
      for (int g = 0; g < 24 && mdl.h != h; g++) press(1'b1);
      if (mdl.h == h && mdl.m == m && mdl.s <= smax) return;
      wait_hms(-1, -1, 0, 61 * CLK_HZ, "goto_wrap");
    end
  endtask

  task automatic set_alarm_0002;
    bus.SetAlarm = 1'b1;
    press(1'b0);
    press(1'b0);
    bus.SetAlarm = 1'b0;
    bus.AlarmEn  = 1'b1;
  endtask

  typedef struct {
    bit         sa;
    bit         hour_key;
    int         reps;
    logic [7:0] ah;
    logic [7:0] am;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1,  8'hF1, 8'h00};
    tbl[1] = '{1'b1, 1'b0, 2,  8'hF1, 8'h02};
    tbl[2] = '{1'b1, 1'b1, 9,  8'h10, 8'h02};
    tbl[3] = '{1'b1, 1'b1, 13, 8'h23, 8'h02};
    tbl[4] = '{1'b1, 1'b1, 1,  8'hF0, 8'h02};
    tbl[5] = '{1'b1, 1'b0, 57, 8'hF0, 8'h59};
    tbl[6] = '{1'b1, 1'b0, 1,  8'hF0, 8'h00};
    tbl[7] = '{1'b0, 1'b0, 3,  8'hF0, 8'h00};

    bus.AdjMinKey = 1'b0; bus.AdjHourKey = 1'b0;
    bus.SetAlarm = 1'b0;  bus.AlarmEn = 1'b0;
    #1 CR = 1'b1;
    cyc(2);
    chk("rst_Hour", bus.Hour, 8'hF0);
    chk("rst_AHour", bus.AHour, 8'hF0);
    CR = 1'b0;
    chk_en = 1'b1;

    // Alarm adjust table, including hour wrap and minute wrap without carry
    foreach (tbl[i]) begin
      bus.SetAlarm = tbl[i].sa;
      for (int r = 0; r < tbl[i].reps; r++) press(tbl[i].hour_key);
      chk($sformatf("tbl%0d_AHour", i), bus.AHour, tbl[i].ah);
      chk($sformatf("tbl%0d_AMin", i), bus.AMinutes, tbl[i].am);
    end
    bus.SetAlarm = 1'b0;

    // Minute adjust at 59 does not carry; a held key pulses once
    goto_time(5, 59, 50);
    bus.AdjMinKey = 1'b1;
    cyc(2);
    chk("adj_lat2_Min", bus.Minutes, 8'h59);
    cyc(1);
    chk("adj_lat3_Min", bus.Minutes, 8'h00);
    chk("adj_lat3_Hour", bus.Hour, 8'hF5);
    cyc(8);
    chk("adj_hold_Min", bus.Minutes, 8'h00);
    bus.AdjMinKey = 1'b0;
    cyc(3);

    // Day rollover
    goto_time(23, 59, 57);
    wait_hms(23, 59, 58, 4 * 60 * CLK_HZ, "w_235958");
    chk("roll_Hour23", bus.Hour, 8'h23);
    chk("roll_Sec58", bus.Second, 8'h58);
    wait_hms(-1, -1, 59, 2 * CLK_HZ, "w_59");
    chk("roll_Sec59", bus.Second, 8'h59);
    chk("roll_Min59", bus.Minutes, 8'h59);
    wait_hms(-1, -1, 0, 2 * CLK_HZ, "w_00");
    chk("roll_HourF0", bus.Hour, 8'hF0);
    chk("roll_Min00", bus.Minutes, 8'h00);
    chk("roll_Sec00", bus.Second, 8'h00);

    // Minute adjust landing on the carrying tick gives +1 only
    do_reset;
    wait_hms(0, 0, 59, 70 * CLK_HZ, "w_000059");
    for (int i = 0; i < 2 * CLK_HZ && mdl.pc != 1; i++) @(negedge CP1);
    bus.AdjMinKey = 1'b1;
    cyc(1);
    bus.AdjMinKey = 1'b0;
    wait_hms(-1, -1, 0, 2 * CLK_HZ, "w_tickadj");
    chk("tickadj_Hour", bus.Hour, 8'hF0);
    chk("tickadj_Min", bus.Minutes, 8'h01);
    chk("tickadj_Sec", bus.Second, 8'h00);

    // Alarm rings two cycles after the tick to 00:02:00 and times out after 3 ticks
    do_reset;
    set_alarm_0002;
    chk("al_AMin", bus.AMinutes, 8'h02);
    wait_hms(0, 1, 59, 150 * CLK_HZ, "w_000159");
    wait_hms(0, 2, 0, 2 * CLK_HZ, "w_000200");
    chk("al_Tick", 8'(bus.TickSec), 8'h01);
    chk("al_notyet", 8'(bus.Alarm), 8'h00);
    cyc(1);
    chk("al_rise", 8'(bus.Alarm), 8'h01);
    wait_hms(0, 2, 2, 3 * CLK_HZ, "w_000202");
    chk("al_ring2", 8'(bus.Alarm), 8'h01);
    wait_hms(0, 2, 3, 2 * CLK_HZ, "w_000203");
    chk("al_timeout", 8'(bus.Alarm), 8'h00);

    // Key pulse dismisses a ring; alarm hour moves on
    bus.SetAlarm = 1'b1;
    press(1'b0);
    wait_hms(0, 3, 0, 70 * CLK_HZ, "w_000300");
    cyc(1);
    chk("dis_ring", 8'(bus.Alarm), 8'h01);
    bus.AdjHourKey = 1'b1;
    cyc(1);
    bus.AdjHourKey = 1'b0;
    cyc(1);
    chk("dis_still", 8'(bus.Alarm), 8'h01);
    chk("dis_AHour0", bus.AHour, 8'hF0);
    cyc(1);
    chk("dis_off", 8'(bus.Alarm), 8'h00);
    chk("dis_AHour1", bus.AHour, 8'hF1);
    bus.SetAlarm = 1'b0;
    wait_hms(0, 3, 2, 3 * CLK_HZ, "w_000302");
    chk("dis_norering", 8'(bus.Alarm), 8'h00);

    // Reset asserted mid-ring clears everything without a clock edge
    do_reset;
    set_alarm_0002;
    wait_hms(0, 2, 1, 150 * CLK_HZ, "w_000201");
    chk("mr_ring", 8'(bus.Alarm), 8'h01);
    #3 CR = 1'b1;
    #1;
    chk("mr_Hour", bus.Hour, 8'hF0);
    chk("mr_Min", bus.Minutes, 8'h00);
    chk("mr_Sec", bus.Second, 8'h00);
    chk("mr_Alarm", 8'(bus.Alarm), 8'h00);
    chk("mr_Tick", 8'(bus.TickSec), 8'h00);
    chk("mr_AMin", bus.AMinutes, 8'h00);
    @(negedge CP1);
    CR = 1'b0;
    bus.SetAlarm = 1'b0;

    // Random keys, alarm mode and enable against the model
    bus.AlarmEn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      bus.AdjMinKey  = ($urandom_range(0, 7) == 0);
      bus.AdjHourKey = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 31) == 0) bus.SetAlarm = ~bus.SetAlarm;
      if ($urandom_range(0, 63) == 0) bus.AlarmEn  = ~bus.AlarmEn;
      @(negedge CP1);
    end
    bus.AdjMinKey = 1'b0;
    bus.AdjHourKey = 1'b0;
    cyc(4);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end
endmodule
